// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access. Grants and outputs are registered.
// Fairness under contention is round-robin. Define MEM_ARB_TIMEOUT_EN to add the no-ack watchdog.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_done,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [63:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_done,
    output logic [63:0]       d_rdata,
    output logic              m_req,
    output logic              m_we,
    output logic [1:0]        m_size,
    output logic [ADDR_W-1:0] m_addr,
    output logic [63:0]       m_wdata,
    input  logic [63:0]       m_rdata,
    input  logic              m_ack,
    output logic              err,
    output logic              busy
);

    if (DATA_W != 64 || TIMEOUT < 1) begin : g_bad_param
        $error("mem_port_arbiter: DATA_W must be 64 and TIMEOUT at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_I_XFER = 2'd1,
        S_D_XFER = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [1:0] SIZE_WORD = 2'b10;

    state_t              r_state,   w_state_nxt;
    logic                r_last_d,  w_last_d_nxt;
    logic                r_i_gnt,   w_i_gnt_nxt;
    logic                r_d_gnt,   w_d_gnt_nxt;
    logic                r_i_done,  w_i_done_nxt;
    logic                r_d_done,  w_d_done_nxt;
    logic [31:0]         r_i_rdata, w_i_rdata_nxt;
    logic [63:0]         r_d_rdata, w_d_rdata_nxt;
    logic                r_m_req,   w_m_req_nxt;
    logic                r_m_we,    w_m_we_nxt;
    logic [1:0]          r_m_size,  w_m_size_nxt;
    logic [ADDR_W-1:0]   r_m_addr,  w_m_addr_nxt;
    logic [63:0]         r_m_wdata, w_m_wdata_nxt;
    logic                r_err,     w_err_nxt;
    logic                r_busy,    w_busy_nxt;
    logic                w_is_d;
    logic                w_timeout;
    logic [63:0]         w_load_data;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned WDOG_W = $clog2(TIMEOUT + 1);
    logic [WDOG_W-1:0]   r_wdog, w_wdog_nxt;

    assign w_timeout = (r_wdog == WDOG_W'(TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // Zero-extend the loaded value to the latched access size; stores return zero.
    always_comb begin
        w_load_data = 64'd0;
        if (!r_m_we) begin
            case (r_m_size)
                2'b00:   w_load_data = {56'd0, m_rdata[7:0]};
                2'b01:   w_load_data = {48'd0, m_rdata[15:0]};
                2'b10:   w_load_data = {32'd0, m_rdata[31:0]};
                default: w_load_data = m_rdata;
            endcase
        end
    end

    assign w_is_d = (r_state == S_D_XFER);

    always_comb begin
        w_state_nxt   = r_state;
        w_last_d_nxt  = r_last_d;
        w_i_gnt_nxt   = 1'b0;
        w_d_gnt_nxt   = 1'b0;
        w_i_done_nxt  = 1'b0;
        w_d_done_nxt  = 1'b0;
        w_i_rdata_nxt = r_i_rdata;
        w_d_rdata_nxt = r_d_rdata;
        w_m_req_nxt   = 1'b0;
        w_m_we_nxt    = r_m_we;
        w_m_size_nxt  = r_m_size;
        w_m_addr_nxt  = r_m_addr;
        w_m_wdata_nxt = r_m_wdata;
        w_err_nxt     = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        w_wdog_nxt    = r_wdog;
`endif
        case (r_state)
            S_IDLE: begin
                // Fetch wins a tie unless it owned the port last.
                if (i_req && (!d_req || r_last_d)) begin
                    w_state_nxt   = S_I_XFER;
                    w_i_gnt_nxt   = 1'b1;
                    w_m_req_nxt   = 1'b1;
                    w_m_we_nxt    = 1'b0;
                    w_m_size_nxt  = SIZE_WORD;
                    w_m_addr_nxt  = i_addr;
                    w_m_wdata_nxt = 64'd0;
`ifdef MEM_ARB_TIMEOUT_EN
                    w_wdog_nxt    = '0;
`endif
                end else if (d_req) begin
                    w_state_nxt   = S_D_XFER;
                    w_d_gnt_nxt   = 1'b1;
                    w_m_req_nxt   = 1'b1;
                    w_m_we_nxt    = d_we;
                    w_m_size_nxt  = d_size;
                    w_m_addr_nxt  = d_addr;
                    w_m_wdata_nxt = d_wdata;
`ifdef MEM_ARB_TIMEOUT_EN
                    w_wdog_nxt    = '0;
`endif
                end
            end
            S_I_XFER, S_D_XFER: begin
                if (m_ack || w_timeout) begin
                    w_state_nxt  = S_DONE;
                    w_last_d_nxt = w_is_d;
                    w_err_nxt    = !m_ack;
                    if (w_is_d) begin
                        w_d_done_nxt  = 1'b1;
                        w_d_rdata_nxt = m_ack ? w_load_data : 64'd0;
                    end else begin
                        w_i_done_nxt  = 1'b1;
                        w_i_rdata_nxt = m_ack ? m_rdata[31:0] : 32'd0;
                    end
                end else begin
                    w_m_req_nxt = 1'b1;
                    w_i_gnt_nxt = !w_is_d;
                    w_d_gnt_nxt = w_is_d;
`ifdef MEM_ARB_TIMEOUT_EN
                    w_wdog_nxt  = r_wdog + WDOG_W'(1);
`endif
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_last_d  <= 1'b1;
            r_i_gnt   <= 1'b0;
            r_d_gnt   <= 1'b0;
            r_i_done  <= 1'b0;
            r_d_done  <= 1'b0;
            r_i_rdata <= 32'd0;
            r_d_rdata <= 64'd0;
            r_m_req   <= 1'b0;
            r_m_we    <= 1'b0;
            r_m_size  <= 2'b00;
            r_m_addr  <= '0;
            r_m_wdata <= 64'd0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_last_d  <= w_last_d_nxt;
            r_i_gnt   <= w_i_gnt_nxt;
            r_d_gnt   <= w_d_gnt_nxt;
            r_i_done  <= w_i_done_nxt;
            r_d_done  <= w_d_done_nxt;
            r_i_rdata <= w_i_rdata_nxt;
            r_d_rdata <= w_d_rdata_nxt;
            r_m_req   <= w_m_req_nxt;
            r_m_we    <= w_m_we_nxt;
            r_m_size  <= w_m_size_nxt;
            r_m_addr  <= w_m_addr_nxt;
            r_m_wdata <= w_m_wdata_nxt;
            r_err     <= w_err_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= w_wdog_nxt;
        end
    end
`endif

    assign i_gnt   = r_i_gnt;
    assign d_gnt   = r_d_gnt;
    assign i_done  = r_i_done;
    assign d_done  = r_d_done;
    assign i_rdata = r_i_rdata;
    assign d_rdata = r_d_rdata;
    assign m_req   = r_m_req;
    assign m_we    = r_m_we;
    assign m_size  = r_m_size;
    assign m_addr  = r_m_addr;
    assign m_wdata = r_m_wdata;
    assign err     = r_err;
    assign busy    = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; stimulus on the falling edge, outputs sampled there too.
// The watchdog scenario runs only when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W = 64;

    logic              clock = 1'b0;
    logic              reset;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt, i_done;
    logic [31:0]       i_rdata;
    logic              d_req, d_we;
    logic [1:0]        d_size;
    logic [ADDR_W-1:0] d_addr;
    logic [63:0]       d_wdata;
    logic              d_gnt, d_done;
    logic [63:0]       d_rdata;
    logic              m_req, m_we;
    logic [1:0]        m_size;
    logic [ADDR_W-1:0] m_addr;
    logic [63:0]       m_wdata;
    logic [63:0]       m_rdata;
    logic              m_ack;
    logic              err, busy;

    int n_pass  = 0;
    int n_total = 0;

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(15)) dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack), .err(err), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_size = 2'b00; d_addr = '0; d_wdata = '0;
        m_rdata = '0; m_ack = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // Stimulus only: one data access acked on its first transfer cycle, observations returned.
    task automatic data_op(input logic we, input logic [1:0] size, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic [63:0] mrd,
                           output logic o_gnt, output logic o_we, output logic [1:0] o_size,
                           output logic [63:0] o_wdata, output logic o_done,
                           output logic [63:0] o_rdata);
        d_req = 1'b1; d_we = we; d_size = size; d_addr = addr; d_wdata = wdata;
        tick();
        o_gnt = d_gnt; o_we = m_we; o_size = m_size; o_wdata = m_wdata;
        m_ack = 1'b1; m_rdata = mrd;
        tick();
        o_done = d_done; o_rdata = d_rdata;
        d_req = 1'b0; m_ack = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        n_total++;
        if ({m_req, i_gnt, d_gnt, i_done, d_done, err, busy, m_we} !== 8'h00) begin
            $display("FAIL reset_ctrl: got %b want 00000000",
                     {m_req, i_gnt, d_gnt, i_done, d_done, err, busy, m_we});
        end else n_pass++;
        n_total++;
        if ({m_addr, m_wdata, d_rdata, i_rdata, m_size} !== 226'd0) begin
            $display("FAIL reset_data: addr %h wdata %h d_rdata %h i_rdata %h size %b want all 0",
                     m_addr, m_wdata, d_rdata, i_rdata, m_size);
        end else n_pass++;
    endtask

    task automatic test_fetch();
        i_req = 1'b1; i_addr = 64'h100;
        tick();
        n_total++;
        if ({m_req, i_gnt, d_gnt, m_we, m_size, busy} !== 7'b1100101 || m_addr !== 64'h100) begin
            $display("FAIL fetch_grant: req/ig/dg/we/size/busy %b addr %h want 1100101 addr 100",
                     {m_req, i_gnt, d_gnt, m_we, m_size, busy}, m_addr);
        end else n_pass++;
        tick();
        n_total++;
        if (m_req !== 1'b1 || i_done !== 1'b0) begin
            $display("FAIL fetch_wait: m_req %b i_done %b want 1 0", m_req, i_done);
        end else n_pass++;
        m_ack = 1'b1; m_rdata = 64'hDEADBEEF_8B020020;
        tick();
        n_total++;
        if (i_done !== 1'b1 || i_rdata !== 32'h8B020020 || m_req !== 1'b0 || i_gnt !== 1'b0) begin
            $display("FAIL fetch_done: done %b rdata %h req %b gnt %b want 1 8b020020 0 0",
                     i_done, i_rdata, m_req, i_gnt);
        end else n_pass++;
        i_req = 1'b0; m_ack = 1'b0; m_rdata = '0;
        tick();
        n_total++;
        if (i_done !== 1'b0 || busy !== 1'b0 || i_rdata !== 32'h8B020020) begin
            $display("FAIL fetch_idle: done %b busy %b rdata %h want 0 0 8b020020", i_done, busy, i_rdata);
        end else n_pass++;
    endtask

    task automatic test_loads();
        logic [63:0] want [4];
        logic g, we_o, dn;
        logic [1:0] sz;
        logic [63:0] wd, rd;
        want[0] = 64'h80;
        want[1] = 64'hFF80;
        want[2] = 64'hFFFF_FF80;
        want[3] = 64'hFFFF_FFFF_FFFF_FF80;
        for (int s = 0; s < 4; s++) begin
            data_op(1'b0, 2'(s), 64'h2000 + 64'(s), 64'h0, 64'hFFFF_FFFF_FFFF_FF80, g, we_o, sz, wd, dn, rd);
            n_total++;
            if (g !== 1'b1 || we_o !== 1'b0 || sz !== 2'(s) || dn !== 1'b1 || rd !== want[s]) begin
                $display("FAIL load_size%0d: gnt %b we %b size %b done %b rdata %h want 1 0 %0d 1 %h",
                         s, g, we_o, sz, dn, rd, s, want[s]);
            end else n_pass++;
        end
    endtask

    task automatic test_store();
        logic g, we_o, dn;
        logic [1:0] sz;
        logic [63:0] wd, rd;
        data_op(1'b1, 2'b11, 64'h3000, 64'h1234, 64'hAAAA_BBBB_CCCC_DDDD, g, we_o, sz, wd, dn, rd);
        n_total++;
        if (g !== 1'b1 || we_o !== 1'b1 || sz !== 2'b11 || wd !== 64'h1234 || dn !== 1'b1 || rd !== 64'd0) begin
            $display("FAIL store: gnt %b we %b size %b wdata %h done %b rdata %h want 1 1 11 1234 1 0",
                     g, we_o, sz, wd, dn, rd);
        end else n_pass++;
    endtask

    task automatic test_contention();
        apply_reset();
        i_req = 1'b1; i_addr = 64'h400;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'b11; d_addr = 64'h800;
        for (int t = 0; t < 4; t++) begin
            int w = 0;
            logic want_i;
            want_i = ((t % 2) == 0);
            while (!(i_gnt || d_gnt) && w < 8) begin
                tick();
                w++;
            end
            n_total++;
            if (w >= 8) begin
                $display("FAIL contend_timeout%0d: no grant within 8 cycles", t);
            end else if (i_gnt !== want_i || d_gnt !== !want_i) begin
                $display("FAIL contend_order%0d: i_gnt %b d_gnt %b want %b %b", t, i_gnt, d_gnt, want_i, !want_i);
            end else n_pass++;
            m_ack = 1'b1; m_rdata = 64'h1;
            tick();
            n_total++;
            if (i_done !== want_i || d_done !== !want_i) begin
                $display("FAIL contend_done%0d: i_done %b d_done %b want %b %b", t, i_done, d_done, want_i, !want_i);
            end else n_pass++;
            m_ack = 1'b0;
            if (t == 3) begin
                i_req = 1'b0; d_req = 1'b0;
            end
            tick();
        end
    endtask

    task automatic test_robust();
        m_ack = 1'b1;
        tick();
        n_total++;
        if (busy !== 1'b0 || d_done !== 1'b0 || i_done !== 1'b0 || m_req !== 1'b0) begin
            $display("FAIL stray_ack: busy %b d_done %b i_done %b m_req %b want 0 0 0 0", busy, d_done, i_done, m_req);
        end else n_pass++;
        m_ack = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'b01; d_addr = 64'h5550;
        tick();
        d_req = 1'b0; d_addr = 64'h9990; d_size = 2'b11; d_we = 1'b1;
        tick();
        tick();
        n_total++;
        if (m_addr !== 64'h5550 || m_size !== 2'b01 || m_we !== 1'b0 || m_req !== 1'b1 || d_gnt !== 1'b1) begin
            $display("FAIL latch_stable: addr %h size %b we %b req %b gnt %b want 5550 01 0 1 1",
                     m_addr, m_size, m_we, m_req, d_gnt);
        end else n_pass++;
        m_ack = 1'b1; m_rdata = 64'h0000_0000_0001_ABCD;
        tick();
        n_total++;
        if (d_done !== 1'b1 || d_rdata !== 64'hABCD) begin
            $display("FAIL drop_req_done: done %b rdata %h want 1 abcd", d_done, d_rdata);
        end else n_pass++;
        m_ack = 1'b0;
        i_req = 1'b1; i_addr = 64'h600;
        tick();
        n_total++;
        if (i_gnt !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL req_in_done: i_gnt %b busy %b want 0 0", i_gnt, busy);
        end else n_pass++;
        tick();
        n_total++;
        if (i_gnt !== 1'b1 || m_addr !== 64'h600) begin
            $display("FAIL req_after_done: i_gnt %b addr %h want 1 600", i_gnt, m_addr);
        end else n_pass++;
        m_ack = 1'b1;
        tick();
        i_req = 1'b0; m_ack = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 64'h7000;
        tick();
        n_total++;
        if (d_gnt !== 1'b1 || m_req !== 1'b1) begin
            $display("FAIL midrst_pre: d_gnt %b m_req %b want 1 1", d_gnt, m_req);
        end else n_pass++;
        #2 reset = 1'b0;
        #1;
        n_total++;
        if ({m_req, d_gnt, busy, d_done} !== 4'b0000 || m_addr !== 64'd0) begin
            $display("FAIL midrst_async: req/gnt/busy/done %b addr %h want 0000 0",
                     {m_req, d_gnt, busy, d_done}, m_addr);
        end else n_pass++;
        d_req = 1'b0; m_ack = 1'b1;
        tick();
        tick();
        n_total++;
        if (d_done !== 1'b0 || m_req !== 1'b0) begin
            $display("FAIL midrst_nodone: d_done %b m_req %b want 0 0", d_done, m_req);
        end else n_pass++;
        m_ack = 1'b0;
        reset = 1'b1;
        tick();
    endtask

`ifdef MEM_ARB_TIMEOUT_EN
    task automatic test_watchdog();
        int k = 0;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'b11; d_addr = 64'hA000;
        m_rdata = 64'h5555;
        tick();
        while (!d_done && k < 40) begin
            tick();
            k++;
        end
        n_total++;
        if (d_done !== 1'b1 || k !== 15 || err !== 1'b1 || d_rdata !== 64'd0) begin
            $display("FAIL watchdog: done %b cycles %0d err %b rdata %h want 1 15 1 0", d_done, k, err, d_rdata);
        end else n_pass++;
        d_req = 1'b0;
        tick();
        n_total++;
        if (busy !== 1'b0 || err !== 1'b0 || d_done !== 1'b0) begin
            $display("FAIL watchdog_idle: busy %b err %b done %b want 0 0 0", busy, err, d_done);
        end else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_fetch();
        test_loads();
        test_store();
        test_contention();
        test_robust();
        test_reset_mid();
`ifdef MEM_ARB_TIMEOUT_EN
        test_watchdog();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
